// File: rtl/calc_pkg.sv
// Shared calculator-path definitions: result width, BCD digit coding and the
// converter state set, imported by the calculator, converter and display blocks.
package calc_pkg;

  localparam int RESULT_W = 10;
  localparam int DIGIT_W  = 4;

  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/calc_result_bcd.sv
// Iterative signed-binary to sign + BCD converter (shift-add-3, one bit per clock).
// Optional build macro LEAD_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module calc_result_bcd #(
  parameter int RESULT_W = 10,
  parameter int NDIG     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RESULT_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  neg,
  output logic [4*NDIG-1:0]     bcd
);

  import calc_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int              CNT_W = $clog2(RESULT_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RESULT_W - 1);
  localparam int              BCD_W = DIGIT_W * NDIG;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [RESULT_W-1:0] mag;
  logic [RESULT_W-1:0] mag_in;
  logic [BCD_W-1:0]    acc;
  logic [BCD_W-1:0]    acc_adj;
  logic [BCD_W-1:0]    acc_next;
  logic [BCD_W-1:0]    bcd_final;

  // The most negative input maps to 2^(RESULT_W-1), which still fits unsigned.
  assign mag_in = in_data[RESULT_W-1] ? (~in_data + 1'b1) : in_data;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign acc_next = {acc_adj[BCD_W-2:0], mag[RESULT_W-1]};

`ifdef LEAD_ZERO_BLANK_EN
  // The ones digit is never blanked so a zero result still shows "0".
  always_comb begin
    logic lead;
    bcd_final = acc_next;
    lead      = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && (acc_next[i*DIGIT_W +: DIGIT_W] == '0)) begin
        bcd_final[i*DIGIT_W +: DIGIT_W] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_final = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      mag   <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      bcd   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            neg   <= in_data[RESULT_W-1];
            mag   <= mag_in;
            acc   <= '0;
            cnt   <= '0;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          acc <= acc_next;
          mag <= {mag[RESULT_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          // bcd only updates here, so it stays stable for the whole DONE phase.
          if (cnt == LAST) begin
            bcd   <= bcd_final;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_calc_result_bcd.sv
// Randomised self-checking bench for calc_result_bcd against a decimal-arithmetic
// reference model; honours LEAD_ZERO_BLANK_EN when defined.
module tb_calc_result_bcd;

  localparam int RW   = 10;
  localparam int NDIG = 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic            neg;
  logic [4*NDIG-1:0] bcd;

  int tests;
  int failed;

  calc_result_bcd #(.RESULT_W(RW), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .neg       (neg),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4*NDIG-1:0] modelBcd(input int value);
    logic [4*NDIG-1:0] r;
    int m;
    int d;
    bit lead;
    r = '0;
    m = (value < 0) ? -value : value;
    for (int i = 0; i < NDIG; i++) begin
      d = m % 10;
      r[4*i +: 4] = 4'(d);
      m = m / 10;
    end
`ifdef LEAD_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the block re-enters IDLE.
  task automatic applyStimulus(input int value, input int hold, input bit early);
    int t;
    logic [4*NDIG-1:0] expBcd;
    logic expNeg;
    int v;
    expBcd = modelBcd(value);
    expNeg = (value < 0);
    v = value;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v[RW-1:0];
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = RW'($urandom);
    out_ready = early;
    for (int k = 1; k <= RW; k++) begin
      @(negedge clk);
      checkOutput("latency_out_valid", 32'(out_valid), (k == RW) ? 32'd1 : 32'd0);
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      out_ready = early && (k < RW);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = RW'($urandom);
    end
    in_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_neg", 32'(neg), 32'(expNeg));
      checkOutput("hold_bcd", 32'(bcd), 32'(expBcd));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data  = RW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("done_out_valid", 32'(out_valid), 32'd1);
    checkOutput("done_neg", 32'(neg), 32'(expNeg));
    checkOutput("done_bcd", 32'(bcd), 32'(expBcd));
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int v;
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_neg", 32'(neg), 32'd0);
    checkOutput("reset_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(7, 0, 1'b0);
    applyStimulus(54, 0, 1'b0);
    applyStimulus(-1, 0, 1'b0);
    applyStimulus(-512, 0, 1'b0);
    applyStimulus(511, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(100, 20, 1'b0);
    applyStimulus(-90, 3, 1'b1);

    // Reset in the middle of converting a negative value.
    in_valid = 1'b1;
    v = -200;
    in_data = v[RW-1:0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_neg", 32'(neg), 32'd0);
    checkOutput("midrst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    applyStimulus(123, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(0, 1023)) - 512;
      applyStimulus(v, int'($urandom_range(0, 3)), 1'(($urandom_range(0, 3) == 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/calc_result_bcd.md
# calc_result_bcd

Sequential converter directly downstream of the `calculator` block. It accepts one signed two's-complement result word per handshake and produces a sign flag plus packed BCD digits for the display stage. Conversion uses an iterative double-dabble (shift-add-3) datapath: one bit per clock, with valid/ready handshakes on both sides.

## Interface
- `RESULT_W`, default 10: input result width, signed two's complement. This matches the calculator `out` port.
- `NDIG`, default 3: number of BCD digits. Must satisfy 10^NDIG > 2^(RESULT_W-1).
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the block can accept a word.
- `in_data` input, `RESULT_W` bits: signed result to convert.
- `out_valid` output, 1 bit: `neg` and `bcd` hold a completed conversion.
- `out_ready` input, 1 bit: the downstream stage consumes the output.
- `neg` output, 1 bit: 1 when the input was negative.
- `bcd` output, 4·`NDIG` bits: magnitude digits, least significant digit in `[3:0]`.

## Operation
- **States:** IDLE, CONV, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - latch `neg` = `in_data` MSB;
    - latch shift register `mag` = |`in_data|`, computed as `RESULT_W`-bit unsigned;
    - clear the BCD accumulator;
    - set `cnt`=0;
    - go to CONV.
- **Magnitude:** uses ~x+1 when the input is negative. The most negative value (-512 at default width) yields unsigned 512, which is correct.
- **CONV:** each cycle performs one iteration.
  1. Every BCD digit ≥5 gets +3.
  2. `{bcd_acc, mag}` shifts left by 1.
  3. `cnt` increments.
  - After iteration number `RESULT_W` (`cnt`==`RESULT_W`-1), go to DONE.
- **DONE:**
  - `out_valid`=1; `neg` and `bcd` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in CONV and DONE.
- **Registered outputs:** `neg`, `bcd`, `out_valid` and `in_ready` are all registered or decoded from state only. No combinational path exists from `in_valid` or `out_ready` to any output.
- **Zero:** input 0 gives `neg`=0 and all digits 0. Negative zero cannot occur.

## Timing
- **Reset values:**
  - state=IDLE;
  - `in_ready`=1, `out_valid`=0;
  - `neg`=0, `bcd`=0;
  - `cnt`=0.
- **Latency:** the accept edge is E0. Iterations occur on E1..E`RESULT_W`. `out_valid` rises after edge E`RESULT_W`, which is 10 cycles at the default width.
- **Output handshake:** `out_valid` stays high until the edge where `out_ready`=1. The block returns to IDLE on that edge, so `in_ready`=1 the following cycle.
- **Throughput:** minimum initiation interval is `RESULT_W`+2 cycles.
- **Ignored inputs:** `in_valid` outside IDLE is ignored. `in_data` changes after acceptance have no effect.
- **Early `out_ready`:** `out_ready` high before DONE has no effect and is not remembered.
- **Reset during operation:** asserting `rst_n`=0 in any state immediately forces the reset values. The partial conversion is discarded and no `out_valid` is produced for it.

## Configuration
- **Macro:** `LEAD_ZERO_BLANK_EN`.
- **Defined:** digit positions above the most significant nonzero digit output 4'hF (the blank code). The ones digit is never blanked, so 0 displays as "0". Blanking is applied when entering DONE, so `bcd` is still stable throughout DONE.
- **Undefined:** leading digits output 0. Latency and the handshake are identical in both builds.

## Structure
- **Shared package `calc_pkg`:**
  - `RESULT_W`=10, `DIGIT_W`=4;
  - `BCD_BLANK`=4'hF;
  - the state enum `conv_state_t` {IDLE, CONV, DONE}.
  - The calculator and display blocks import the same package.
- **Sub-module `bcd_add3`:** a 4-bit combinational block that adds 3 when the digit is ≥5. It is instantiated `NDIG` times in a generate loop.
- The counter, shift register and FSM stay in the top level.

## Test plan
1. **Positive result:** reset, then accept `in_data`=10'b0000000111 (+7) → `out_valid` after 10 cycles.
   - `neg`=0, `bcd`=12'h007;
   - with the macro, `bcd`=12'hFF7.
2. **Two-digit and negative results, back-to-back:** send 54 (10'b0000110110), then -1 (10'b1111111111).
   - 54 → `neg`=0, `bcd`=12'h054;
   - -1 → `neg`=1, `bcd`=12'h001 (12'hFF1 with the macro).
   - Check `in_ready` is low throughout CONV and DONE.
3. **Range extremes:**
   - -512 (10'b1000000000) → `neg`=1, `bcd`=12'h512;
   - +511 → `neg`=0, `bcd`=12'h511;
   - 0 → `bcd`=12'h000 (12'hFF0 with the macro).
4. **Backpressure:**
   - Hold `out_ready`=0 for 20 cycles → `out_valid`, `neg` and `bcd` stay stable and a second `in_valid` is not accepted.
   - Release `out_ready` → the block returns to IDLE one edge later.
5. **Reset mid-conversion:** pulse `rst_n` low at iteration 5 → outputs return to reset values asynchronously and no stale `out_valid` appears.
   - A following conversion of 123 gives `bcd`=12'h123.
6. **Input changes after acceptance:** change `in_data` on the cycle after acceptance → the result still reflects the originally accepted value.
